// File: rtl/mc_ctrl_ws.sv
// ============================================================================
//  Module   : mc_ctrl_ws
//  Purpose  : Multi-cycle MIPS control unit (IF/ID/EXE/MEM/WB) with memory
//             wait states, driving datapath muxes and write enables.
//  Option   : define MCCTRL_MEM_HS_EN to replace the fixed MEM_WAIT counter
//             with a mem_ready handshake.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_ctrl_ws #(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Zero,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       EXTOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [1:0] GPRSel,
  output logic [1:0] WDSel,
  output logic       IorD,
  output logic       retire,
  output logic       illegal,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IF  = 3'b000,
    S_ID  = 3'b001,
    S_EXE = 3'b010,
    S_MEM = 3'b011,
    S_WB  = 3'b100
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_JAL   = 6'b000011;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_ANDI  = 6'b001100;
  localparam logic [5:0] c_OP_ORI   = 6'b001101;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;

  localparam logic [2:0] c_ALU_ADD  = 3'b001;
  localparam logic [2:0] c_ALU_SUB  = 3'b010;
  localparam logic [2:0] c_ALU_AND  = 3'b011;
  localparam logic [2:0] c_ALU_OR   = 3'b100;
  localparam logic [2:0] c_ALU_SLT  = 3'b101;
  localparam logic [2:0] c_ALU_SLTU = 3'b110;

  state_t state_q, state_d;
  logic   w_mem_done;

  logic       w_illegal, w_j, w_jal, w_jr, w_beq, w_bne;
  logic       w_lw, w_sw, w_imm, w_zext;
  logic [2:0] w_alu_op;

  always_comb begin
    w_illegal = 1'b0;
    w_j       = 1'b0;
    w_jal     = 1'b0;
    w_jr      = 1'b0;
    w_beq     = 1'b0;
    w_bne     = 1'b0;
    w_lw      = 1'b0;
    w_sw      = 1'b0;
    w_imm     = 1'b0;
    w_zext    = 1'b0;
    w_alu_op  = c_ALU_ADD;
    case (Op)
      c_OP_RTYPE: begin
        case (Funct)
          6'b100000, 6'b100001: w_alu_op = c_ALU_ADD;
          6'b100010, 6'b100011: w_alu_op = c_ALU_SUB;
          6'b100100:            w_alu_op = c_ALU_AND;
          6'b100101:            w_alu_op = c_ALU_OR;
          6'b101010:            w_alu_op = c_ALU_SLT;
          6'b101011:            w_alu_op = c_ALU_SLTU;
          6'b001000:            w_jr     = 1'b1;
          default:              w_illegal = 1'b1;
        endcase
      end
      c_OP_ADDI: w_imm = 1'b1;
      c_OP_ANDI: begin w_imm = 1'b1; w_zext = 1'b1; w_alu_op = c_ALU_AND; end
      c_OP_ORI:  begin w_imm = 1'b1; w_zext = 1'b1; w_alu_op = c_ALU_OR;  end
      c_OP_LW:   w_lw  = 1'b1;
      c_OP_SW:   w_sw  = 1'b1;
      c_OP_BEQ:  begin w_beq = 1'b1; w_alu_op = c_ALU_SUB; end
      c_OP_BNE:  begin w_bne = 1'b1; w_alu_op = c_ALU_SUB; end
      c_OP_J:    w_j   = 1'b1;
      c_OP_JAL:  w_jal = 1'b1;
      default:   w_illegal = 1'b1;
    endcase
  end

`ifdef MCCTRL_MEM_HS_EN
  assign w_mem_done = mem_ready;
`else
  // Counter sits at 0 outside IF/MEM, so it is already loaded on entry.
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_unused_mem_ready;

  assign w_unused_mem_ready = mem_ready;
  assign w_mem_done         = (cnt_q == CNT_W'(MEM_WAIT));

  always_comb begin
    cnt_d = '0;
    if ((state_q == S_IF || state_q == S_MEM) && !w_mem_done)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  assign state_o = state_q;

  always_comb begin
    state_d  = state_q;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    MemRead  = 1'b0;
    EXTOp    = 1'b1;
    ALUSrcA  = 1'b1;
    ALUSrcB  = 2'b00;
    ALUOp    = c_ALU_ADD;
    PCSource = 2'b00;
    GPRSel   = 2'b00;
    WDSel    = 2'b00;
    IorD     = 1'b0;
    retire   = 1'b0;
    illegal  = 1'b0;
    // While in reset every output stays at its idle default.
    if (!rst) begin
      case (state_q)
        S_IF: begin
          MemRead = 1'b1;
          ALUSrcA = 1'b0;
          ALUSrcB = 2'b01;
          if (w_mem_done) begin
            PCWrite = 1'b1;
            IRWrite = 1'b1;
            state_d = S_ID;
          end
        end
        S_ID: begin
          ALUSrcA = 1'b0;
          ALUSrcB = 2'b11;
          if (w_illegal) begin
            illegal = 1'b1;
            state_d = S_IF;
          end else if (w_j || w_jal) begin
            PCSource = 2'b10;
            PCWrite  = 1'b1;
            retire   = 1'b1;
            state_d  = S_IF;
            if (w_jal) begin
              RegWrite = 1'b1;
              GPRSel   = 2'b10;
              WDSel    = 2'b10;
            end
          end else if (w_jr) begin
            PCSource = 2'b11;
            PCWrite  = 1'b1;
            retire   = 1'b1;
            state_d  = S_IF;
          end else begin
            state_d = S_EXE;
          end
        end
        S_EXE: begin
          ALUOp = w_alu_op;
          if (w_beq || w_bne) begin
            PCSource = 2'b01;
            PCWrite  = w_beq ? Zero : ~Zero;
            retire   = 1'b1;
            state_d  = S_IF;
          end else if (w_lw || w_sw) begin
            ALUSrcB = 2'b10;
            state_d = S_MEM;
          end else begin
            if (w_imm) begin
              ALUSrcB = 2'b10;
              EXTOp   = ~w_zext;
            end
            state_d = S_WB;
          end
        end
        S_MEM: begin
          IorD    = 1'b1;
          MemRead = w_lw;
          if (w_mem_done) begin
            if (w_sw) begin
              MemWrite = 1'b1;
              retire   = 1'b1;
              state_d  = S_IF;
            end else begin
              state_d = S_WB;
            end
          end
        end
        S_WB: begin
          RegWrite = 1'b1;
          retire   = 1'b1;
          GPRSel   = (w_imm || w_lw) ? 2'b01 : 2'b00;
          WDSel    = w_lw ? 2'b01 : 2'b00;
          state_d  = S_IF;
        end
        default: state_d = S_IF;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl_ws.sv
// ============================================================================
//  Module   : tb_mc_ctrl_ws
//  Purpose  : Directed self-checking bench for mc_ctrl_ws (MEM_WAIT=0 and 2).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mc_ctrl_ws;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic [5:0] Op = 6'd0;
  logic [5:0] Funct = 6'd0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // a_* : MEM_WAIT=0 instance, b_* : MEM_WAIT=2 instance
  logic a_RegWrite, a_MemWrite, a_PCWrite, a_IRWrite, a_MemRead, a_EXTOp, a_ALUSrcA;
  logic a_IorD, a_retire, a_illegal;
  logic [1:0] a_ALUSrcB, a_PCSource, a_GPRSel, a_WDSel;
  logic [2:0] a_ALUOp, a_state;
  logic b_RegWrite, b_MemWrite, b_PCWrite, b_IRWrite, b_MemRead, b_EXTOp, b_ALUSrcA;
  logic b_IorD, b_retire, b_illegal;
  logic [1:0] b_ALUSrcB, b_PCSource, b_GPRSel, b_WDSel;
  logic [2:0] b_ALUOp, b_state;

  mc_ctrl_ws #(.MEM_WAIT(0), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .Zero(Zero), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
    .RegWrite(a_RegWrite), .MemWrite(a_MemWrite), .PCWrite(a_PCWrite), .IRWrite(a_IRWrite),
    .MemRead(a_MemRead), .EXTOp(a_EXTOp), .ALUSrcA(a_ALUSrcA), .ALUSrcB(a_ALUSrcB),
    .ALUOp(a_ALUOp), .PCSource(a_PCSource), .GPRSel(a_GPRSel), .WDSel(a_WDSel),
    .IorD(a_IorD), .retire(a_retire), .illegal(a_illegal), .state_o(a_state));

  mc_ctrl_ws #(.MEM_WAIT(2), .CNT_W(4)) u_b (
    .clk(clk), .rst(rst), .Zero(Zero), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
    .RegWrite(b_RegWrite), .MemWrite(b_MemWrite), .PCWrite(b_PCWrite), .IRWrite(b_IRWrite),
    .MemRead(b_MemRead), .EXTOp(b_EXTOp), .ALUSrcA(b_ALUSrcA), .ALUSrcB(b_ALUSrcB),
    .ALUOp(b_ALUOp), .PCSource(b_PCSource), .GPRSel(b_GPRSel), .WDSel(b_WDSel),
    .IorD(b_IorD), .retire(b_retire), .illegal(b_illegal), .state_o(b_state));

  // en  = {PCWrite, IRWrite, RegWrite, MemWrite, MemRead, retire, illegal}
  // mux = {EXTOp, ALUSrcA, ALUSrcB, ALUOp, PCSource, GPRSel, WDSel, IorD}
  logic [6:0]  a_en, b_en;
  logic [13:0] a_mux, b_mux;
  assign a_en  = {a_PCWrite, a_IRWrite, a_RegWrite, a_MemWrite, a_MemRead, a_retire, a_illegal};
  assign b_en  = {b_PCWrite, b_IRWrite, b_RegWrite, b_MemWrite, b_MemRead, b_retire, b_illegal};
  assign a_mux = {a_EXTOp, a_ALUSrcA, a_ALUSrcB, a_ALUOp, a_PCSource, a_GPRSel, a_WDSel, a_IorD};
  assign b_mux = {b_EXTOp, b_ALUSrcA, b_ALUSrcB, b_ALUOp, b_PCSource, b_GPRSel, b_WDSel, b_IorD};

  localparam logic [6:0]  EN_IF   = 7'b1100100;
  localparam logic [6:0]  EN_IFW  = 7'b0000100;
  localparam logic [6:0]  EN_WB   = 7'b0010010;
  localparam logic [13:0] MUX_DEF = {1'b1, 1'b1, 2'b00, 3'b001, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [13:0] MUX_IF  = {1'b1, 1'b0, 2'b01, 3'b001, 2'b00, 2'b00, 2'b00, 1'b0};
  localparam logic [13:0] MUX_ID  = {1'b1, 1'b0, 2'b11, 3'b001, 2'b00, 2'b00, 2'b00, 1'b0};

  task automatic nxt;
    @(posedge clk);
    #4;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(posedge clk); #3;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk); #3;
    n_cmp++; if ({a_state, a_en} !== {3'd0, 7'd0}) begin n_fail++; $display("FAIL reset_a got st=%0d en=%b want st=0 en=0000000", a_state, a_en); end
    n_cmp++; if (a_mux !== MUX_DEF) begin n_fail++; $display("FAIL reset_a_mux got %b want %b", a_mux, MUX_DEF); end
    n_cmp++; if ({b_state, b_en} !== {3'd0, 7'd0}) begin n_fail++; $display("FAIL reset_b got st=%0d en=%b want st=0 en=0000000", b_state, b_en); end
  endtask

  task automatic test_add;
    logic [9:0] ev [5];
    ev = '{{3'd0, EN_IF}, {3'd1, 7'd0}, {3'd2, 7'd0}, {3'd4, EN_WB}, {3'd0, EN_IF}};
    Op = 6'b000000; Funct = 6'b100000;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) nxt();
      n_cmp++; if ({a_state, a_en} !== ev[i]) begin n_fail++; $display("FAIL add_c%0d got %b want %b", i + 1, {a_state, a_en}, ev[i]); end
      if (i == 0) begin n_cmp++; if (a_mux !== MUX_IF) begin n_fail++; $display("FAIL add_if_mux got %b want %b", a_mux, MUX_IF); end end
      if (i == 1) begin n_cmp++; if (a_mux !== MUX_ID) begin n_fail++; $display("FAIL add_id_mux got %b want %b", a_mux, MUX_ID); end end
      if (i == 3) begin n_cmp++; if (a_mux !== MUX_DEF) begin n_fail++; $display("FAIL add_wb_mux got %b want %b", a_mux, MUX_DEF); end end
    end
  endtask

  task automatic test_slt_andi;
    Op = 6'b000000; Funct = 6'b101010;
    do_reset(); nxt(); nxt();
    n_cmp++; if ({a_state, a_ALUOp, a_ALUSrcB} !== {3'd2, 3'b101, 2'b00}) begin n_fail++; $display("FAIL slt_exe got %b want %b", {a_state, a_ALUOp, a_ALUSrcB}, {3'd2, 3'b101, 2'b00}); end
    Op = 6'b001100; Funct = 6'b000000;
    do_reset(); nxt(); nxt();
    n_cmp++; if (a_mux !== {1'b0, 1'b1, 2'b10, 3'b011, 2'b00, 2'b00, 2'b00, 1'b0}) begin n_fail++; $display("FAIL andi_exe_mux got %b want %b", a_mux, {1'b0, 1'b1, 2'b10, 3'b011, 2'b00, 2'b00, 2'b00, 1'b0}); end
    nxt();
    n_cmp++; if ({a_state, a_en, a_GPRSel, a_WDSel} !== {3'd4, EN_WB, 2'b01, 2'b00}) begin n_fail++; $display("FAIL andi_wb got %b want %b", {a_state, a_en, a_GPRSel, a_WDSel}, {3'd4, EN_WB, 2'b01, 2'b00}); end
  endtask

  task automatic test_lw_wait;
    logic [9:0] ev [10];
    int retire_at;
    ev = '{{3'd0, EN_IFW}, {3'd0, EN_IFW}, {3'd0, EN_IF}, {3'd1, 7'd0}, {3'd2, 7'd0},
           {3'd3, 7'b0000100}, {3'd3, 7'b0000100}, {3'd3, 7'b0000100}, {3'd4, EN_WB}, {3'd0, EN_IFW}};
    retire_at = 0;
    Op = 6'b100011; Funct = 6'b000000;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i > 0) nxt();
      if (b_retire === 1'b1 && retire_at == 0) retire_at = i + 1;
      n_cmp++; if ({b_state, b_en} !== ev[i]) begin n_fail++; $display("FAIL lw_c%0d got %b want %b", i + 1, {b_state, b_en}, ev[i]); end
      if (i == 5) begin n_cmp++; if (b_IorD !== 1'b1) begin n_fail++; $display("FAIL lw_mem_iord got %b want 1", b_IorD); end end
      if (i == 8) begin n_cmp++; if ({b_GPRSel, b_WDSel} !== 4'b0101) begin n_fail++; $display("FAIL lw_wb_sel got %b want 0101", {b_GPRSel, b_WDSel}); end end
    end
    n_cmp++; if (retire_at != 9) begin n_fail++; $display("FAIL lw_cycles got %0d want 9", retire_at); end
  endtask

  task automatic test_bne;
    Op = 6'b000101; Funct = 6'b000000; Zero = 1'b0;
    do_reset(); nxt(); nxt();
    n_cmp++; if ({a_state, a_en} !== {3'd2, 7'b1000010}) begin n_fail++; $display("FAIL bne_z0_exe got %b want %b", {a_state, a_en}, {3'd2, 7'b1000010}); end
    n_cmp++; if (a_mux !== {1'b1, 1'b1, 2'b00, 3'b010, 2'b01, 2'b00, 2'b00, 1'b0}) begin n_fail++; $display("FAIL bne_exe_mux got %b want %b", a_mux, {1'b1, 1'b1, 2'b00, 3'b010, 2'b01, 2'b00, 2'b00, 1'b0}); end
    nxt(); Zero = 1'b1; #1;
    n_cmp++; if ({a_state, a_en} !== {3'd0, EN_IF}) begin n_fail++; $display("FAIL bne_next_if got %b want %b", {a_state, a_en}, {3'd0, EN_IF}); end
    nxt(); nxt();
    n_cmp++; if ({a_state, a_en} !== {3'd2, 7'b0000010}) begin n_fail++; $display("FAIL bne_z1_exe got %b want %b", {a_state, a_en}, {3'd2, 7'b0000010}); end
    nxt();
    n_cmp++; if (a_state !== 3'd0) begin n_fail++; $display("FAIL bne_z1_ret got %0d want 0", a_state); end
    Zero = 1'b0;
  endtask

  task automatic test_jumps;
    Op = 6'b000011; Funct = 6'b000000;
    do_reset(); nxt();
    n_cmp++; if ({a_state, a_en} !== {3'd1, 7'b1010010}) begin n_fail++; $display("FAIL jal_id got %b want %b", {a_state, a_en}, {3'd1, 7'b1010010}); end
    n_cmp++; if (a_mux !== {1'b1, 1'b0, 2'b11, 3'b001, 2'b10, 2'b10, 2'b10, 1'b0}) begin n_fail++; $display("FAIL jal_id_mux got %b want %b", a_mux, {1'b1, 1'b0, 2'b11, 3'b001, 2'b10, 2'b10, 2'b10, 1'b0}); end
    nxt();
    n_cmp++; if (a_state !== 3'd0) begin n_fail++; $display("FAIL jal_ret got %0d want 0", a_state); end
    Op = 6'b000000; Funct = 6'b001000;
    do_reset(); nxt();
    n_cmp++; if ({a_state, a_en, a_PCSource, a_GPRSel} !== {3'd1, 7'b1000010, 2'b11, 2'b00}) begin n_fail++; $display("FAIL jr_id got %b want %b", {a_state, a_en, a_PCSource, a_GPRSel}, {3'd1, 7'b1000010, 2'b11, 2'b00}); end
  endtask

  task automatic test_illegal;
    Op = 6'b111111; Funct = 6'b000000;
    do_reset(); nxt();
    n_cmp++; if ({a_state, a_en} !== {3'd1, 7'b0000001}) begin n_fail++; $display("FAIL ill_op_id got %b want %b", {a_state, a_en}, {3'd1, 7'b0000001}); end
    nxt();
    n_cmp++; if ({a_state, a_en} !== {3'd0, EN_IF}) begin n_fail++; $display("FAIL ill_op_next got %b want %b", {a_state, a_en}, {3'd0, EN_IF}); end
    Op = 6'b000000; Funct = 6'b111111;
    do_reset(); nxt();
    n_cmp++; if ({a_state, a_en} !== {3'd1, 7'b0000001}) begin n_fail++; $display("FAIL ill_funct_id got %b want %b", {a_state, a_en}, {3'd1, 7'b0000001}); end
  endtask

  task automatic test_reset_abort;
    logic [9:0] ev [5];
    int mw_seen;
    ev = '{{3'd0, EN_IF}, {3'd1, 7'd0}, {3'd2, 7'd0}, {3'd3, 7'b0001010}, {3'd0, EN_IF}};
    mw_seen = 0;
    Op = 6'b101011; Funct = 6'b000000;
    do_reset(); nxt(); nxt();
    n_cmp++; if ({a_state, a_ALUSrcB} !== {3'd2, 2'b10}) begin n_fail++; $display("FAIL sw_exe got %b want %b", {a_state, a_ALUSrcB}, {3'd2, 2'b10}); end
    rst = 1'b1; #1;
    n_cmp++; if ({a_state, a_en, a_mux} !== {3'd0, 7'd0, MUX_DEF}) begin n_fail++; $display("FAIL abort_now got %b want %b", {a_state, a_en, a_mux}, {3'd0, 7'd0, MUX_DEF}); end
    for (int i = 0; i < 3; i++) begin
      nxt();
      if (a_MemWrite !== 1'b0) mw_seen++;
    end
    n_cmp++; if (mw_seen != 0) begin n_fail++; $display("FAIL abort_memwrite got %0d want 0", mw_seen); end
    rst = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) nxt();
      n_cmp++; if ({a_state, a_en} !== ev[i]) begin n_fail++; $display("FAIL sw_c%0d got %b want %b", i + 1, {a_state, a_en}, ev[i]); end
    end
  endtask

`ifdef MCCTRL_MEM_HS_EN
  task automatic test_hs_sw;
    int mw_cnt;
    mw_cnt = 0;
    Op = 6'b101011; Funct = 6'b000000; mem_ready = 1'b1;
    do_reset(); nxt(); nxt(); nxt();
    mem_ready = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) nxt();
      n_cmp++; if ({a_state, a_en, a_IorD} !== {3'd3, 7'd0, 1'b1}) begin n_fail++; $display("FAIL hs_wait_c%0d got %b want %b", i, {a_state, a_en, a_IorD}, {3'd3, 7'd0, 1'b1}); end
    end
    mem_ready = 1'b1; #1;
    n_cmp++; if ({a_state, a_en} !== {3'd3, 7'b0001010}) begin n_fail++; $display("FAIL hs_done got %b want %b", {a_state, a_en}, {3'd3, 7'b0001010}); end
    nxt();
    if (a_MemWrite !== 1'b0) mw_cnt++;
    n_cmp++; if ({a_state, mw_cnt} !== {3'd0, 32'd0}) begin n_fail++; $display("FAIL hs_after got st=%0d extra=%0d want st=0 extra=0", a_state, mw_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_slt_andi();
`ifndef MCCTRL_MEM_HS_EN
    test_lw_wait();
`endif
    test_bne();
    test_jumps();
    test_illegal();
    test_reset_abort();
`ifdef MCCTRL_MEM_HS_EN
    test_hs_sw();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
